// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants, response record and instruction-ROM
//                contents for the instruction fetch-response path.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Byte address of instruction word 0
    localparam logic [31:0] C_BASE_DEFAULT = 32'h0000_3000;

    // Instruction returned in place of a faulting fetch
    localparam logic [31:0] C_NOP = 32'h0000_0000;

    // One fetch response as it travels through the pipeline and FIFO
    typedef struct packed {
        logic [31:0] inst;
        logic [31:2] addr;
        logic        fault;
    } imem_rsp_t;

    // Fixed ROM image: word index in the upper bits, an ADDI opcode below
    function automatic logic [31:0] imem_rom_word(input logic [31:0] idx);
        return (idx << 12) | 32'h0000_0013;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : imem_rsp_fifo
//  Description : Small circular FIFO holding fetch responses until the
//                consumer takes them. Synchronous clear drops all entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  imem_rsp_t                      wdata_i,
    input  logic                           pop_i,
    output imem_rsp_t                      rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    imem_rsp_t     mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == C_FULL);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    // Storage array; no reset needed since reads are qualified by count
    always_ff @(posedge clk) begin
        if (w_do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= f_inc(wr_ptr_q);
            end
            if (w_do_pop) begin
                rd_ptr_q <= f_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_resp
//  Description : Fixed-latency instruction fetch. Requests read the ROM,
//                travel a LAT-stage valid-tagged pipeline and land in a
//                credit-protected response FIFO of depth LAT+1.
//                Optional macro IMEM_RANGE_CHECK_EN enables out-of-range
//                fault reporting with NOP substitution.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_resp
    import imem_pkg::*;
#(
    parameter int          LAT  = 2,
    parameter int          AW   = 10,
    parameter logic [31:0] BASE = C_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:2] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic [31:2] rsp_addr,
    output logic        rsp_fault
);

    localparam int          DEPTH       = LAT + 1;
    localparam int          CW          = $clog2(DEPTH + 1);
    localparam logic [31:0] C_IDX_MASK  = (32'd1 << AW) - 32'd1;
    localparam logic [31:2] C_BASE_WORD = BASE[31:2];
    localparam logic [CW-1:0] C_CREDITS = CW'(DEPTH);

    // Lookup
    logic [31:2] w_offset;
    logic [31:0] w_idx;
    logic        w_fault;
    logic [31:0] w_word;
    imem_rsp_t   w_lookup;

    // Pipeline and credit state
    logic [LAT-1:0] pipe_vld_q;
    imem_rsp_t      pipe_data_q [LAT];
    logic [CW-1:0]  inflight_q;
    logic [CW-1:0]  inflight_d;
    logic           req_ready_q;
    logic           req_ready_d;
    logic [CW-1:0]  w_occ_next;

    // FIFO interface
    logic           w_accept;
    logic           w_exit;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    imem_rsp_t      w_head;

    assign req_ready = req_ready_q;
    assign w_accept  = req_valid & req_ready_q;
    assign w_exit    = pipe_vld_q[LAT-1];
    assign w_pop     = rsp_valid & rsp_ready;
    // Exit entries are dropped on flush; the credit limit keeps the FIFO from overflowing
    assign w_push    = w_exit & ~flush & (~w_full | w_pop);

    // ROM lookup with index taken relative to BASE, modulo the array size
    always_comb begin
        w_offset = req_addr - C_BASE_WORD;
        w_idx    = {2'b00, w_offset} & C_IDX_MASK;
`ifdef IMEM_RANGE_CHECK_EN
        w_fault  = ({2'b00, w_offset} > C_IDX_MASK);
        w_word   = w_fault ? C_NOP : imem_rom_word(w_idx);
`else
        w_fault  = 1'b0;
        w_word   = imem_rom_word(w_idx);
`endif
        w_lookup.inst  = w_word;
        w_lookup.addr  = req_addr;
        w_lookup.fault = w_fault;
    end

    // Valid-tagged delay line; flush kills older stages but keeps a same-cycle request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= w_accept;
            if (w_accept) begin
                pipe_data_q[0] <= w_lookup;
            end
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_q[i]  <= flush ? 1'b0 : pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    // Next-state credit accounting: in-flight count plus FIFO occupancy
    always_comb begin
        if (flush) begin
            inflight_d = CW'(w_accept);
            w_occ_next = '0;
        end else begin
            inflight_d = inflight_q + CW'(w_accept) - CW'(w_exit);
            w_occ_next = w_count + CW'(w_push) - CW'(w_pop);
        end
        req_ready_d = ((inflight_d + w_occ_next) < C_CREDITS);
    end

    // Registered credit state; req_ready stays low throughout reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q  <= '0;
            req_ready_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            req_ready_q <= req_ready_d;
        end
    end

    imem_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (w_push),
        .wdata_i (pipe_data_q[LAT-1]),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Idle outputs read as NOP at BASE with no fault
    assign rsp_valid = ~w_empty;
    assign rsp_inst  = w_empty ? 32'h0000_0000 : w_head.inst;
    assign rsp_addr  = w_empty ? C_BASE_WORD : w_head.addr;
    assign rsp_fault = ~w_empty & w_head.fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_resp
//  Description : Directed bench for imem_fetch_resp (LAT=2, AW=10,
//                BASE=0x3000). Cycle table plus flush and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:2] req_addr = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_inst;
    logic [31:2] rsp_addr;
    logic        rsp_fault;

    int n_checks = 0;
    int n_err    = 0;

`ifdef IMEM_RANGE_CHECK_EN
    localparam logic [31:0] LO_INST = 32'h0000_0000;
    localparam logic        LO_FLT  = 1'b1;
    localparam logic [31:0] HI_INST = 32'h0000_0000;
    localparam logic        HI_FLT  = 1'b1;
`else
    localparam logic [31:0] LO_INST = 32'h003F_F013;
    localparam logic        LO_FLT  = 1'b0;
    localparam logic [31:0] HI_INST = 32'h0000_0013;
    localparam logic        HI_FLT  = 1'b0;
`endif

    imem_fetch_resp dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [29:0] a;
        logic        rr;
        logic        e_rdy;
        logic        e_val;
        logic [29:0] e_addr;
        logic [31:0] e_inst;
        logic        e_flt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [29:0] a, input logic rr,
                       input logic e_rdy, input logic e_val, input logic [29:0] e_addr,
                       input logic [31:0] e_inst, input logic e_flt);
        tbl.push_back('{v, a, rr, e_rdy, e_val, e_addr, e_inst, e_flt});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [29:0] a, input logic f, input logic rr);
        req_valid = v;
        req_addr  = a;
        flush     = f;
        rsp_ready = rr;
    endtask

    task automatic chk_rsp(input string name, input logic [29:0] a, input logic [31:0] inst,
                           input logic flt);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_addr"},  32'(rsp_addr),  32'(a));
        chk({name, "_inst"},  rsp_inst,       inst);
        chk({name, "_fault"}, 32'(rsp_fault), 32'(flt));
    endtask

    initial begin
        // Each row: outputs expected at this negedge, then inputs for the next edge
        //   v  addr        rr   rdy val  addr        inst          fault
        add(1, 30'hC00, 1,   0, 0, 30'h0,   32'h0,        0); // r0  just released
        add(1, 30'hC00, 1,   1, 0, 30'h0,   32'h0,        0); // r1
        add(1, 30'hC01, 1,   1, 0, 30'h0,   32'h0,        0); // r2
        add(1, 30'hC02, 1,   1, 0, 30'h0,   32'h0,        0); // r3
        add(1, 30'hC03, 1,   0, 1, 30'hC00, 32'h0000_0013, 0); // r4  first rsp
        add(1, 30'hC03, 1,   1, 1, 30'hC01, 32'h0000_1013, 0); // r5
        add(1, 30'hC04, 1,   1, 1, 30'hC02, 32'h0000_2013, 0); // r6
        add(1, 30'hC05, 1,   1, 0, 30'h0,   32'h0,        0); // r7
        add(0, 30'h0,   1,   0, 1, 30'hC03, 32'h0000_3013, 0); // r8
        add(0, 30'h0,   1,   1, 1, 30'hC04, 32'h0000_4013, 0); // r9
        add(0, 30'h0,   1,   1, 1, 30'hC05, 32'h0000_5013, 0); // r10
        add(1, 30'hC10, 0,   1, 0, 30'h0,   32'h0,        0); // r11 stall phase
        add(1, 30'hC11, 0,   1, 0, 30'h0,   32'h0,        0); // r12
        add(1, 30'hC12, 0,   1, 0, 30'h0,   32'h0,        0); // r13
        add(1, 30'hC13, 0,   0, 1, 30'hC10, 32'h0001_0013, 0); // r14 credits gone
        add(1, 30'hC13, 0,   0, 1, 30'hC10, 32'h0001_0013, 0); // r15
        add(0, 30'h0,   0,   0, 1, 30'hC10, 32'h0001_0013, 0); // r16
        add(0, 30'h0,   1,   0, 1, 30'hC10, 32'h0001_0013, 0); // r17 drain
        add(0, 30'h0,   1,   1, 1, 30'hC11, 32'h0001_1013, 0); // r18
        add(0, 30'h0,   1,   1, 1, 30'hC12, 32'h0001_2013, 0); // r19
        add(1, 30'hBFF, 1,   1, 0, 30'h0,   32'h0,        0); // r20 below BASE
        add(0, 30'h0,   1,   1, 0, 30'h0,   32'h0,        0); // r21
        add(0, 30'h0,   1,   1, 0, 30'h0,   32'h0,        0); // r22
        add(0, 30'h0,   1,   1, 1, 30'hBFF, LO_INST,      LO_FLT); // r23
        add(1, 30'h1000, 1,  1, 0, 30'h0,   32'h0,        0); // r24 one past top
        add(1, 30'hFFF, 1,   1, 0, 30'h0,   32'h0,        0); // r25 last word
        add(0, 30'h0,   1,   1, 0, 30'h0,   32'h0,        0); // r26
        add(0, 30'h0,   1,   1, 1, 30'h1000, HI_INST,     HI_FLT); // r27
        add(0, 30'h0,   1,   1, 1, 30'hFFF, 32'h003F_F013, 0); // r28
        add(0, 30'h0,   1,   1, 0, 30'h0,   32'h0,        0); // r29

        // Reset with a request pending: nothing may be accepted
        drv(1, 30'hC00, 0, 1);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_inst",  rsp_inst,       32'h0);
        chk("rst_addr",  32'(rsp_addr),  32'hC00);
        chk("rst_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("r%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("r%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                chk($sformatf("r%0d_addr", i),  32'(rsp_addr),  32'(tbl[i].e_addr));
                chk($sformatf("r%0d_inst", i),  rsp_inst,       tbl[i].e_inst);
                chk($sformatf("r%0d_fault", i), 32'(rsp_fault), 32'(tbl[i].e_flt));
            end
            drv(tbl[i].v, tbl[i].a, 1'b0, tbl[i].rr);
            @(negedge clk);
        end

        // Flush with two in flight and one buffered; D00 held until accepted
        drv(1, 30'hC20, 0, 0); @(negedge clk);
        drv(1, 30'hC21, 0, 0); @(negedge clk);
        drv(1, 30'hC22, 0, 0); @(negedge clk);
        chk("pre_flush_ready", 32'(req_ready), 32'd0);
        chk_rsp("pre_flush", 30'hC20, 32'h0002_0013, 1'b0);
        drv(1, 30'hD00, 1, 0); @(negedge clk);
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd1);
        drv(1, 30'hD00, 0, 1); @(negedge clk);
        chk("flush_lat0", 32'(rsp_valid), 32'd0);
        drv(0, 30'h0, 0, 1); @(negedge clk);
        chk("flush_lat1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk_rsp("flush_d00", 30'hD00, 32'h0010_0013, 1'b0);
        @(negedge clk);
        chk("flush_after", 32'(rsp_valid), 32'd0);

        // Flush with a same-cycle request: only the new one survives
        drv(1, 30'hC30, 0, 0); @(negedge clk);
        drv(1, 30'hD10, 1, 0); @(negedge clk);
        chk("sflush_valid", 32'(rsp_valid), 32'd0);
        chk("sflush_ready", 32'(req_ready), 32'd1);
        drv(0, 30'h0, 0, 1); @(negedge clk);
        chk("sflush_lat1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk_rsp("sflush_d10", 30'hD10, 32'h0011_0013, 1'b0);
        @(negedge clk);
        chk("sflush_after", 32'(rsp_valid), 32'd0);

        // Reset mid-operation with two requests in flight
        drv(1, 30'hC40, 0, 1); @(negedge clk);
        drv(1, 30'hC41, 0, 1); @(negedge clk);
        drv(0, 30'h0, 0, 1);
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        chk("mrst_addr",  32'(rsp_addr),  32'hC00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rel_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mrst_stale%0d", k), 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
